// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: steps the PE array through the passes of one layer and hands each ofmap to the host.
// Optional pass watchdog (timeout_err, TMO_CYCLES) is built only when LAYER_SEQ_TIMEOUT_EN is defined.
module layer_seq_ctrl #(
   parameter int PASS_W = 8,
   parameter int TMO_W  = 16
`ifdef LAYER_SEQ_TIMEOUT_EN
   ,
   parameter int unsigned TMO_CYCLES = 32'h0000_FFFF
`endif
) (
   input  logic              core_clk,
   input  logic              core_reset,
   input  logic              start,
   input  logic [PASS_W-1:0] cfg_num_passes,
   input  logic              start_pass,
   output logic              pass_go,
   input  logic              array_done,
   output logic              ofmap_dump,
   input  logic              dump_done,
   output logic [PASS_W-1:0] pass_idx,
   output logic              busy,
   output logic              done,
`ifdef LAYER_SEQ_TIMEOUT_EN
   output logic              timeout_err,
`endif
   output logic [2:0]        fsm_state
);

   // Handshakes: start, array_done and dump_done are sampled on the rising edge and act only in
   // the state that waits for them; dump_done must fall again (ACK) before the next pass can count it.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_PASS = 3'd1,
      GO        = 3'd2,
      COMPUTE   = 3'd3,
      DUMP      = 3'd4,
      ACK       = 3'd5,
      NEXT      = 3'd6,
      DONE      = 3'd7
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [PASS_W-1:0] last_idx;
   logic              start_ok;
   logic              is_last;
`ifdef LAYER_SEQ_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
   logic [TMO_W-1:0] wdog;
   logic             tmo_hit;
`endif

   assign start_ok = start && ((state == IDLE) || (state == DONE));
   assign is_last  = (pass_idx == last_idx);
`ifdef LAYER_SEQ_TIMEOUT_EN
   assign tmo_hit  = (state == COMPUTE) && !array_done && (wdog == TMO_LAST);
`endif

   always_ff @(posedge core_clk) begin
      if (core_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (start) state_next = WAIT_PASS;
         WAIT_PASS:  if (start_pass) state_next = GO;
         GO:         state_next = COMPUTE;
         COMPUTE: begin
            if (array_done) begin
               state_next = DUMP;
`ifdef LAYER_SEQ_TIMEOUT_EN
            end else if (tmo_hit) begin
               state_next = DONE;
`endif
            end
         end
         DUMP:       if (dump_done) state_next = ACK;
         ACK:        if (!dump_done) state_next = NEXT;
         NEXT:       state_next = is_last ? DONE : WAIT_PASS;
         default:    state_next = IDLE;
      endcase
   end

   // A zero pass count runs one pass, so the stored value is the index of the final pass.
   always_ff @(posedge core_clk) begin
      if (core_reset) begin
         last_idx <= '0;
         pass_idx <= '0;
      end else if (start_ok) begin
         last_idx <= (cfg_num_passes == '0) ? '0 : cfg_num_passes - PASS_W'(1);
         pass_idx <= '0;
      end else if ((state == NEXT) && !is_last) begin
         pass_idx <= pass_idx + PASS_W'(1);
      end
   end

`ifdef LAYER_SEQ_TIMEOUT_EN
   always_ff @(posedge core_clk) begin
      if (core_reset) begin
         wdog        <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == GO) begin
            wdog <= '0;
         end else if (state == COMPUTE) begin
            wdog <= wdog + TMO_W'(1);
         end
         if (start_ok) begin
            timeout_err <= 1'b0;
         end else if (tmo_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end
`endif

   assign pass_go    = (state == GO);
   assign ofmap_dump = (state == DUMP);
   assign done       = (state == DONE);
   assign busy       = (state != IDLE) && (state != DONE);
   assign fsm_state  = state;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl; the watchdog scenario is compiled in with LAYER_SEQ_TIMEOUT_EN.
module tb_layer_seq_ctrl;

   localparam int PASS_W = 8;
   localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_GO = 3'd2, S_COMP = 3'd3,
                          S_DUMP = 3'd4, S_ACK = 3'd5, S_DONE = 3'd7;

   logic              core_clk;
   logic              core_reset;
   logic              start;
   logic [PASS_W-1:0] cfg_num_passes;
   logic              start_pass;
   logic              pass_go;
   logic              array_done;
   logic              ofmap_dump;
   logic              dump_done;
   logic [PASS_W-1:0] pass_idx;
   logic              busy;
   logic              done;
   logic [2:0]        fsm_state;
`ifdef LAYER_SEQ_TIMEOUT_EN
   logic              timeout_err;
`endif

   int errors = 0;
   int checks = 0;
   int go_count = 0;
   int dump_count = 0;
   logic dump_prev = 1'b0;
   logic [PASS_W-1:0] idx_seen[$];
   logic [PASS_W-1:0] exp_q[$];

   layer_seq_ctrl #(
      .PASS_W(PASS_W),
      .TMO_W(16)
`ifdef LAYER_SEQ_TIMEOUT_EN
      ,
      .TMO_CYCLES(20)
`endif
   ) dut (
      .core_clk(core_clk),
      .core_reset(core_reset),
      .start(start),
      .cfg_num_passes(cfg_num_passes),
      .start_pass(start_pass),
      .pass_go(pass_go),
      .array_done(array_done),
      .ofmap_dump(ofmap_dump),
      .dump_done(dump_done),
      .pass_idx(pass_idx),
      .busy(busy),
      .done(done),
`ifdef LAYER_SEQ_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .fsm_state(fsm_state)
   );

   // clock / reset
   initial begin
      core_clk = 1'b0;
      forever #5 core_clk = ~core_clk;
   end

   // Pulse/window monitor, sampled on the falling edge.
   always @(negedge core_clk) begin
      dump_prev <= ofmap_dump;
      if (pass_go) begin
         go_count <= go_count + 1;
         idx_seen.push_back(pass_idx);
      end
      if (ofmap_dump && !dump_prev) dump_count <= dump_count + 1;
   end

   // driver tasks
   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic pulse_start(input logic [PASS_W-1:0] n);
      cfg_num_passes = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Runs one pass from WAIT_PASS with start_pass already high.
   task automatic do_pass(input int dump_hold);
      tick();
      tick();
      repeat (2) tick();
      array_done = 1'b1;
      tick();
      array_done = 1'b0;
      tick();
      dump_done = 1'b1;
      repeat (dump_hold) tick();
      dump_done = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      core_reset = 1'b1;
      start = 1'b1;
      start_pass = 1'b1;
      array_done = 1'b1;
      dump_done = 1'b1;
      cfg_num_passes = 8'd4;
      repeat (2) tick();
      checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, S_IDLE); end
      checks++; if (pass_go !== 1'b0) begin errors++; $display("FAIL reset_pass_go got=%b exp=0", pass_go); end
      checks++; if (ofmap_dump !== 1'b0) begin errors++; $display("FAIL reset_ofmap_dump got=%b exp=0", ofmap_dump); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (pass_idx !== 8'd0) begin errors++; $display("FAIL reset_pass_idx got=%0d exp=0", pass_idx); end
`ifdef LAYER_SEQ_TIMEOUT_EN
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
`endif
      start = 1'b0;
      start_pass = 1'b0;
      array_done = 1'b0;
      dump_done = 1'b0;
      core_reset = 1'b0;
      tick();
   endtask

   task automatic test_single_pass();
      int go0, dump0;
      go0 = go_count;
      dump0 = dump_count;
      pulse_start(8'd1);
      start_pass = 1'b1;
      checks++; if (fsm_state !== S_WAIT || busy !== 1'b1) begin errors++; $display("FAIL single_wait state=%0d busy=%b exp state=1 busy=1", fsm_state, busy); end
      tick();
      checks++; if (pass_go !== 1'b1) begin errors++; $display("FAIL single_pass_go got=%b exp=1", pass_go); end
      tick();
      checks++; if (pass_go !== 1'b0 || fsm_state !== S_COMP) begin errors++; $display("FAIL single_go_one_cycle pass_go=%b state=%0d exp 0/3", pass_go, fsm_state); end
      repeat (3) tick();
      array_done = 1'b1;
      tick();
      array_done = 1'b0;
      checks++; if (ofmap_dump !== 1'b1) begin errors++; $display("FAIL single_dump_rise got=%b exp=1", ofmap_dump); end
      repeat (2) tick();
      checks++; if (ofmap_dump !== 1'b1) begin errors++; $display("FAIL single_dump_hold got=%b exp=1", ofmap_dump); end
      dump_done = 1'b1;
      tick();
      checks++; if (ofmap_dump !== 1'b0) begin errors++; $display("FAIL single_dump_drop got=%b exp=0", ofmap_dump); end
      repeat (2) tick();
      checks++; if (fsm_state !== S_ACK) begin errors++; $display("FAIL single_ack_hold got=%0d exp=%0d", fsm_state, S_ACK); end
      dump_done = 1'b0;
      repeat (2) tick();
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_done done=%b busy=%b exp 1/0", done, busy); end
      checks++; if (pass_idx !== 8'd0) begin errors++; $display("FAIL single_pass_idx got=%0d exp=0", pass_idx); end
      checks++; if (go_count - go0 !== 1) begin errors++; $display("FAIL single_go_count got=%0d exp=1", go_count - go0); end
      checks++; if (dump_count - dump0 !== 1) begin errors++; $display("FAIL single_dump_count got=%0d exp=1", dump_count - dump0); end
      repeat (3) tick();
      checks++; if (done !== 1'b1 || fsm_state !== S_DONE) begin errors++; $display("FAIL single_done_hold done=%b state=%0d", done, fsm_state); end
   endtask

   task automatic test_multi_pass();
      int go0, dump0, base;
      go0 = go_count;
      dump0 = dump_count;
      base = idx_seen.size();
      exp_q = {8'd0, 8'd1, 8'd2};
      start_pass = 1'b1;
      pulse_start(8'd3);
      checks++; if (done !== 1'b0 || pass_idx !== 8'd0) begin errors++; $display("FAIL multi_restart done=%b idx=%0d exp 0/0", done, pass_idx); end
      repeat (3) do_pass(1);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL multi_done got=%b exp=1", done); end
      checks++; if (go_count - go0 !== 3) begin errors++; $display("FAIL multi_go_count got=%0d exp=3", go_count - go0); end
      checks++; if (dump_count - dump0 !== 3) begin errors++; $display("FAIL multi_dump_count got=%0d exp=3", dump_count - dump0); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (idx_seen.size() <= base + i || idx_seen[base + i] !== exp_q[i]) begin
            errors++;
            $display("FAIL multi_idx_seq[%0d] got=%0d exp=%0d", i, (idx_seen.size() > base + i) ? idx_seen[base + i] : 8'hFF, exp_q[i]);
         end
      end
      repeat (2) tick();
      checks++; if (pass_idx !== 8'd2) begin errors++; $display("FAIL multi_final_idx got=%0d exp=2", pass_idx); end
   endtask

   task automatic test_dump_hold();
      int go0, dump0;
      start_pass = 1'b1;
      pulse_start(8'd2);
      go0 = go_count;
      dump0 = dump_count;
      do_pass(4);
      checks++; if (pass_idx !== 8'd1 || fsm_state !== S_WAIT) begin errors++; $display("FAIL hold_advance idx=%0d state=%0d exp 1/1", pass_idx, fsm_state); end
      checks++; if (go_count - go0 !== 1 || dump_count - dump0 !== 1) begin errors++; $display("FAIL hold_counted_once go=%0d dump=%0d exp 1/1", go_count - go0, dump_count - dump0); end
      do_pass(1);
      checks++; if (done !== 1'b1 || pass_idx !== 8'd1) begin errors++; $display("FAIL hold_done done=%b idx=%0d exp 1/1", done, pass_idx); end
   endtask

   task automatic test_ignored_inputs();
      start_pass = 1'b0;
      pulse_start(8'd2);
      array_done = 1'b1;
      tick();
      array_done = 1'b0;
      checks++; if (fsm_state !== S_WAIT || ofmap_dump !== 1'b0 || pass_idx !== 8'd0) begin errors++; $display("FAIL ign_array_done state=%0d dump=%b idx=%0d", fsm_state, ofmap_dump, pass_idx); end
      tick();
      checks++; if (fsm_state !== S_WAIT || busy !== 1'b1) begin errors++; $display("FAIL ign_array_done_late state=%0d busy=%b", fsm_state, busy); end
      start_pass = 1'b1;
      tick();
      tick();
      cfg_num_passes = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (fsm_state !== S_COMP || pass_idx !== 8'd0 || pass_go !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_start state=%0d idx=%0d go=%b done=%b", fsm_state, pass_idx, pass_go, done); end
      array_done = 1'b1;
      tick();
      array_done = 1'b0;
      dump_done = 1'b1;
      tick();
      dump_done = 1'b0;
      repeat (2) tick();
      checks++; if (fsm_state !== S_WAIT || pass_idx !== 8'd1) begin errors++; $display("FAIL ign_next state=%0d idx=%0d exp 1/1", fsm_state, pass_idx); end
      do_pass(1);
      checks++; if (done !== 1'b1 || pass_idx !== 8'd1) begin errors++; $display("FAIL ign_num_passes done=%b idx=%0d exp 1/1", done, pass_idx); end
   endtask

   task automatic test_reset_mid_pass();
      start_pass = 1'b1;
      pulse_start(8'd3);
      do_pass(1);
      tick();
      tick();
      array_done = 1'b1;
      tick();
      array_done = 1'b0;
      checks++; if (ofmap_dump !== 1'b1 || pass_idx !== 8'd1) begin errors++; $display("FAIL rst_mid_setup dump=%b idx=%0d exp 1/1", ofmap_dump, pass_idx); end
      core_reset = 1'b1;
      start = 1'b1;
      dump_done = 1'b1;
      tick();
      checks++; if (fsm_state !== S_IDLE || ofmap_dump !== 1'b0 || pass_go !== 1'b0) begin errors++; $display("FAIL rst_mid_state state=%0d dump=%b go=%b", fsm_state, ofmap_dump, pass_go); end
      checks++; if (done !== 1'b0 || busy !== 1'b0 || pass_idx !== 8'd0) begin errors++; $display("FAIL rst_mid_outputs done=%b busy=%b idx=%0d", done, busy, pass_idx); end
      core_reset = 1'b0;
      dump_done = 1'b0;
      start = 1'b0;
      pulse_start(8'd3);
      checks++; if (fsm_state !== S_WAIT || pass_idx !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL rst_mid_restart state=%0d idx=%0d busy=%b", fsm_state, pass_idx, busy); end
      repeat (3) do_pass(1);
      checks++; if (done !== 1'b1 || pass_idx !== 8'd2) begin errors++; $display("FAIL rst_mid_complete done=%b idx=%0d exp 1/2", done, pass_idx); end
   endtask

`ifdef LAYER_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      start_pass = 1'b1;
      pulse_start(8'd1);
      tick();
      tick();
      repeat (19) tick();
      checks++; if (fsm_state !== S_COMP || done !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early state=%0d done=%b err=%b", fsm_state, done, timeout_err); end
      tick();
      checks++; if (done !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_fire done=%b err=%b exp 1/1", done, timeout_err); end
      repeat (2) tick();
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", timeout_err); end
      pulse_start(8'd1);
      checks++; if (timeout_err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL tmo_clear err=%b done=%b exp 0/0", timeout_err, done); end
      do_pass(1);
      checks++; if (done !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_normal_after done=%b err=%b exp 1/0", done, timeout_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_dump_hold();
      test_ignored_inputs();
      test_reset_mid_pass();
`ifdef LAYER_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
